// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op encodings,
// FSM states, division iteration count and the iteration counter type.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 5;

  typedef logic [CNT_W-1:0] cnt_t;

  // Magnitude of a 32-bit operand; unsigned operands pass through unchanged.
  function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX-stage pipeline (master) and the mul/div unit (slave).
// The cancel flush input exists only when MULDIV_CANCEL_EN is defined.
interface muldiv_if;

  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        op_ready;
  logic        busy;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic [1:0]  hilo_we;
`ifdef MULDIV_CANCEL_EN
  logic        cancel;

  modport master (
    output op_valid, op, src_a, src_b, cancel,
    input  op_ready, busy, hi_wdata, lo_wdata, hilo_we
  );

  modport slave (
    input  op_valid, op, src_a, src_b, cancel,
    output op_ready, busy, hi_wdata, lo_wdata, hilo_we
  );
`else
  modport master (
    output op_valid, op, src_a, src_b,
    input  op_ready, busy, hi_wdata, lo_wdata, hilo_we
  );

  modport slave (
    input  op_valid, op, src_a, src_b,
    output op_ready, busy, hi_wdata, lo_wdata, hilo_we
  );
`endif

endinterface

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module muldiv_div_step (
  input  logic [32:0] rem_in,
  input  logic        next_bit,
  input  logic [31:0] divisor,
  output logic [32:0] rem_out,
  output logic        q_bit
);

  logic [33:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted = {rem_in, next_bit};
    q_bit   = (shifted >= {2'b00, divisor});
    diff    = shifted[32:0] - {1'b0, divisor};
    rem_out = q_bit ? diff : shifted[32:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit feeding the HI/LO pair with a one-cycle write pulse.
// Define MULDIV_CANCEL_EN to add the pipeline-flush cancel input.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  state_t      state;
  state_t      next_state;
  cnt_t        cnt;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvsr_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        cancel;
  logic        accept;
  logic        signed_div;
  logic        mul_last;
  logic        div_last;
  logic        op_ready_c;
  logic        busy_c;
  logic [1:0]  hilo_we_c;

  logic [32:0] step_rem;
  logic        step_q;
  logic [31:0] quo_fin;
  logic [31:0] rem_fin;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;

`ifdef MULDIV_CANCEL_EN
  assign cancel = bus.cancel;
`else
  assign cancel = 1'b0;
`endif

  assign accept     = bus.op_valid && (state == IDLE) && !cancel;
  assign signed_div = (bus.op == OP_DIV);
  assign mul_last   = (cnt == cnt_t'(MUL_LAT - 1));
  assign div_last   = (cnt == cnt_t'(DIV_ITERS - 1));

  muldiv_div_step u_step (
    .rem_in   (rem_q),
    .next_bit (quo_q[31]),
    .divisor  (dvsr_q),
    .rem_out  (step_rem),
    .q_bit    (step_q)
  );

  // Final division result uses the last step combinationally so the write
  // lands on the 32nd iteration edge; divide-by-zero overrides the result.
  always_comb begin
    quo_fin = {quo_q[30:0], step_q};
    rem_fin = step_rem[31:0];
    if (b_q == 32'd0) begin
      div_hi = a_q;
      div_lo = 32'hFFFF_FFFF;
    end else begin
      div_hi = neg_rem_q ? (32'd0 - rem_fin) : rem_fin;
      div_lo = neg_quo_q ? (32'd0 - quo_fin) : quo_fin;
    end
  end

  always_comb begin
    ext_a = {((op_q == OP_MULT) && a_q[31]) ? 32'hFFFF_FFFF : 32'h0, a_q};
    ext_b = {((op_q == OP_MULT) && b_q[31]) ? 32'hFFFF_FFFF : 32'h0, b_q};
    prod  = ext_a * ext_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = bus.op[1] ? DIV : MUL;
      MUL: begin
        if (cancel)        next_state = IDLE;
        else if (mul_last) next_state = DONE;
      end
      DIV: begin
        if (cancel)        next_state = IDLE;
        else if (div_last) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    op_ready_c = (state == IDLE);
    busy_c     = (state != IDLE);
    hilo_we_c  = ((state == DONE) && !cancel) ? 2'b11 : 2'b00;
  end

  // Operands are captured on accept; HI/LO data only change on the DONE-entry edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      op_q      <= 2'b00;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt       <= '0;
            op_q      <= bus.op;
            a_q       <= bus.src_a;
            b_q       <= bus.src_b;
            rem_q     <= '0;
            quo_q     <= abs_val(bus.src_a, signed_div);
            dvsr_q    <= abs_val(bus.src_b, signed_div);
            neg_quo_q <= signed_div && (bus.src_a[31] ^ bus.src_b[31]);
            neg_rem_q <= signed_div && bus.src_a[31];
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (next_state == DONE) begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
          end
        end
        DIV: begin
          cnt   <= cnt + 1'b1;
          rem_q <= step_rem;
          quo_q <= quo_fin;
          if (next_state == DONE) begin
            hi_q <= div_hi;
            lo_q <= div_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.op_ready = op_ready_c;
  assign bus.busy     = busy_c;
  assign bus.hilo_we  = hilo_we_c;
  assign bus.hi_wdata = hi_q;
  assign bus.lo_wdata = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the 5-stage pipeline; executes MULT, MULTU, DIV, DIVU.
- Sits directly upstream of the HI/LO register pair and drives its data and per-half write enables with a one-cycle write pulse.
- Raises busy so pipeline control can stall dependent MFHI/MFLO and following mul/div instructions.

Parameters:
- MUL_LAT, 1, cycles spent in MUL state (1..4); product is taken from latched operands.
- DIV_ITERS, 32, restoring-division iterations, one quotient bit per cycle; fixed at 32.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low; clears all state when 0.
- op_valid  in  1  operation request.
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- src_a  in  32  rs operand (multiplicand/dividend).
- src_b  in  32  rt operand (multiplier/divisor).
- op_ready  out  1  high only in IDLE; request accepted when op_valid && op_ready.
- busy  out  1  high whenever state != IDLE.
- hi_wdata  out  32  high product word or remainder.
- lo_wdata  out  32  low product word or quotient.
- hilo_we  out  2  [1]=HI write, [0]=LO write.

Behaviour:
- Reset (rst=0, async): state=IDLE; hi_wdata=0, lo_wdata=0, hilo_we=0, busy=0, op_ready=1; internal operands/counters=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE: on accept at edge T, latch op, src_a, src_b; go to MUL (op[1]=0) or DIV (op[1]=1). op_valid while not IDLE is ignored (no queueing).
- MUL: stays MUL_LAT cycles, then DONE. MULT: signed 32x32->64; MULTU: unsigned. Registered into hi_wdata/lo_wdata on the DONE-entry edge.
- DIV: latch magnitudes |a|, |b| (signed only) and sign bits; 32 iterations, MSB first, 33-bit partial remainder, then DONE.
- Sign fix on DONE entry: quotient negated if signs differ (DIV only); remainder takes dividend sign.
- INT_MIN / -1: quotient=0x80000000, remainder=0; no trap.
- Divide by zero (either op): iterations still run the full 32 cycles; result forced to HI=src_a, LO=0xFFFFFFFF.
- DONE: one cycle, hilo_we=2'b11, busy=1, op_ready=0; next edge returns to IDLE.
- Latency from accept edge T: multiply write pulse in cycle T+1+MUL_LAT (default T+2); divide in cycle T+33.
- Earliest next accept is the cycle after DONE.
- hi_wdata/lo_wdata hold their last value after DONE until the next result; they are only meaningful while hilo_we!=0.
- hilo_we is 0 in every state except DONE.
- Reset mid-operation: immediate return to IDLE; no write pulse is issued for the aborted operation, including after reset release.

Optional Feature:
- Macro: MULDIV_CANCEL_EN.
- Defined: adds input port cancel (1 bit), driven by pipeline flush on exception.
  - cancel=1 in MUL or DIV: next edge goes to IDLE with no write.
  - cancel=1 during DONE: hilo_we forced to 0 combinationally that cycle; state still returns to IDLE.
  - cancel in IDLE blocks acceptance that cycle.
- Not defined: no cancel port; every accepted operation completes and writes.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state enum (IDLE, MUL, DIV, DONE);
  - DIV_ITERS constant;
  - 5-bit iteration counter width.
- One sub-module: muldiv_div_step, the combinational single restoring-division step (partial remainder, divisor -> next remainder, quotient bit).
- Iteration count, sign handling and FSM stay in muldiv_unit.

Test Plan:
- MULT src_a=0xFFFFFFFD, src_b=7 -> at T+2: hilo_we=11, hi_wdata=0xFFFFFFFF, lo_wdata=0xFFFFFFEB; busy high T+1..T+2.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi_wdata=0xFFFFFFFE, lo_wdata=0x00000001.
- DIV 0xFFFFFFF9 / 2 -> at T+33: lo_wdata=0xFFFFFFFD, hi_wdata=0xFFFFFFFF, single-cycle hilo_we=11.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100 / 0 -> hi=0x00000064, lo=0xFFFFFFFF at T+33.
- rst pulled low in 10th DIV cycle -> busy=0, hilo_we=0, data=0 immediately; no write ever issued after release. New DIVU 9/4 then yields hi=1, lo=2.
- op_valid held high throughout a DIVU -> exactly one accept, no second accept until the cycle after DONE; second op accepted then and completes correctly.
- With MULDIV_CANCEL_EN: cancel=1 at DIV cycle 5 -> IDLE next edge, hilo_we never asserted.
